// File: rtl/mac_rx_fcs_check.sv
// Ethernet RX FCS checker: CRC-32 over the post-SFD stream, strips the 4 FCS bytes, flags bad frames on EOP.
// Optional statistics counters are enabled with `define MAC_RX_FCS_STATS_EN.
module mac_rx_fcs_check #(
  parameter int DATA_WIDTH    = 8,
  parameter int MIN_FRAME_LEN = 64
) (
  input  logic                  mac_clk,
  input  logic                  mac_rst,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_error,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_error,
  output logic [31:0]           stat_frames_ok,
  output logic [31:0]           stat_frames_bad,
  output logic [15:0]           stat_runts
);
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [15:0] MIN_LEN     = 16'(MIN_FRAME_LEN);
  localparam bit          LEN_CHECK   = (MIN_FRAME_LEN != 0);

  generate
    if (DATA_WIDTH != 8) begin : g_bad_width
      $error("mac_rx_fcs_check: DATA_WIDTH must be 8");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM} state_t;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  state_t                       state, state_nxt;
  logic [3:0][DATA_WIDTH-1:0]   line_data;
  logic [3:0]                   line_sop;
  logic [1:0]                   fill_cnt;
  logic [31:0]                  crc, crc_base, crc_nxt;
  logic [15:0]                  len, len_nxt;
  logic                         err_seen, err_nxt;
  logic                         sop_in;
  logic                         restart, push, emit, emit_eop, emit_err, frame_bad;

  assign sop_in   = in_valid & in_startofpacket;
  // A new sop always starts a fresh CRC/length/error context, whatever state we are in.
  assign crc_base = restart ? CRC_INIT : crc;
  assign crc_nxt  = crc_byte(crc_base, in_data);
  assign len_nxt  = restart ? 16'd1 : ((len == 16'hFFFF) ? len : len + 16'd1);
  assign err_nxt  = (restart ? 1'b0 : err_seen) | in_error;
  assign frame_bad = (crc_nxt != CRC_RESIDUE) | err_nxt | (LEN_CHECK && (len_nxt < MIN_LEN));

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    push      = 1'b0;
    emit      = 1'b0;
    emit_eop  = 1'b0;
    emit_err  = 1'b0;
    case (state)
      S_IDLE: begin
        if (sop_in) begin
          restart   = 1'b1;
          state_nxt = in_endofpacket ? S_IDLE : S_FILL;
        end
      end
      S_FILL: begin
        if (sop_in) begin
          restart   = 1'b1;
          state_nxt = in_endofpacket ? S_IDLE : S_FILL;
        end else if (in_valid) begin
          push = 1'b1;
          if (in_endofpacket)      state_nxt = S_IDLE;
          else if (fill_cnt == 2'd3) state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (sop_in) begin
          // Abort: oldest held byte closes the old frame as bad, new byte refills the line.
          emit      = 1'b1;
          emit_eop  = 1'b1;
          emit_err  = 1'b1;
          restart   = 1'b1;
          state_nxt = in_endofpacket ? S_IDLE : S_FILL;
        end else if (in_valid) begin
          emit = 1'b1;
          push = 1'b1;
          if (in_endofpacket) begin
            emit_eop  = 1'b1;
            emit_err  = frame_bad;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge mac_clk or posedge mac_rst) begin
    if (mac_rst) begin
      state             <= S_IDLE;
      line_data         <= '0;
      line_sop          <= '0;
      fill_cnt          <= '0;
      crc               <= CRC_INIT;
      len               <= '0;
      err_seen          <= 1'b0;
      out_valid         <= 1'b0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_error         <= 1'b0;
      out_data          <= '0;
    end else begin
      state <= state_nxt;
      if (restart) begin
        line_data <= {{(3*DATA_WIDTH){1'b0}}, in_data};
        line_sop  <= 4'b0001;
        fill_cnt  <= 2'd1;
      end else if (push) begin
        line_data <= {line_data[2:0], in_data};
        line_sop  <= {line_sop[2:0], 1'b0};
        fill_cnt  <= 2'(fill_cnt + 2'd1);
      end
      if (restart || push) begin
        crc      <= crc_nxt;
        len      <= len_nxt;
        err_seen <= err_nxt;
      end
      out_valid         <= emit;
      out_data          <= emit ? line_data[3] : '0;
      out_startofpacket <= emit & line_sop[3];
      out_endofpacket   <= emit_eop;
      out_error         <= emit_err;
    end
  end

`ifdef MAC_RX_FCS_STATS_EN
  // Runt events: a frame dropped in S_FILL by eop or sop, plus a sop&eop single-byte frame.
  logic [1:0]  runt_inc;
  logic [16:0] runt_sum;
  assign runt_inc = {1'b0, in_valid & (state == S_FILL) & (in_startofpacket | in_endofpacket)}
                  + {1'b0, sop_in & in_endofpacket};
  assign runt_sum = {1'b0, stat_runts} + {15'b0, runt_inc};

  always_ff @(posedge mac_clk or posedge mac_rst) begin
    if (mac_rst) begin
      stat_frames_ok  <= '0;
      stat_frames_bad <= '0;
      stat_runts      <= '0;
    end else begin
      if (emit_eop && !emit_err && stat_frames_ok != 32'hFFFFFFFF)
        stat_frames_ok <= stat_frames_ok + 32'd1;
      if (emit_eop && emit_err && stat_frames_bad != 32'hFFFFFFFF)
        stat_frames_bad <= stat_frames_bad + 32'd1;
      stat_runts <= runt_sum[16] ? 16'hFFFF : runt_sum[15:0];
    end
  end
`else
  assign stat_frames_ok  = '0;
  assign stat_frames_bad = '0;
  assign stat_runts      = '0;
`endif

endmodule

// File: tb/tb_mac_rx_fcs_check.sv
// Directed bench for mac_rx_fcs_check: one instance with the length check off, one with MIN_FRAME_LEN=64.
module tb_mac_rx_fcs_check;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_sop = 1'b0, in_eop = 1'b0, in_valid = 1'b0, in_error = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic        o0_sop, o0_eop, o0_valid, o0_err;
  logic [7:0]  o0_data;
  logic [31:0] s0_ok, s0_bad;
  logic [15:0] s0_runts;
  logic        o1_sop, o1_eop, o1_valid, o1_err;
  logic [7:0]  o1_data;
  logic [31:0] s1_ok, s1_bad;
  logic [15:0] s1_runts;

`ifdef MAC_RX_FCS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  mac_rx_fcs_check #(.DATA_WIDTH(8), .MIN_FRAME_LEN(0)) dut (
    .mac_clk(clk), .mac_rst(rst),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_valid(in_valid),
    .in_data(in_data), .in_error(in_error),
    .out_startofpacket(o0_sop), .out_endofpacket(o0_eop), .out_valid(o0_valid),
    .out_data(o0_data), .out_error(o0_err),
    .stat_frames_ok(s0_ok), .stat_frames_bad(s0_bad), .stat_runts(s0_runts));

  mac_rx_fcs_check #(.DATA_WIDTH(8), .MIN_FRAME_LEN(64)) dut_min (
    .mac_clk(clk), .mac_rst(rst),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_valid(in_valid),
    .in_data(in_data), .in_error(in_error),
    .out_startofpacket(o1_sop), .out_endofpacket(o1_eop), .out_valid(o1_valid),
    .out_data(o1_data), .out_error(o1_err),
    .stat_frames_ok(s1_ok), .stat_frames_bad(s1_bad), .stat_runts(s1_runts));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       err;
    int         cyc;
  } rec_t;

  rec_t       q0[$];
  rec_t       q1[$];
  logic [7:0] fb[$];
  int         is[$];
  int         err_at = -1;

  always @(negedge clk) begin
    if (o0_valid) q0.push_back('{o0_data, o0_sop, o0_eop, o0_err, cyc});
    if (o1_valid) q1.push_back('{o1_data, o1_sop, o1_eop, o1_err, cyc});
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic append_fcs();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (fb[i]) c = crc_upd(c, fb[i]);
    c = ~c;
    fb.push_back(c[7:0]);  fb.push_back(c[15:8]);
    fb.push_back(c[23:16]); fb.push_back(c[31:24]);
  endtask

  // is[i] = cycle stamp at which the output popped by byte i becomes visible
  task automatic drive_frame(input bit gaps, input int extra_sop);
    is.delete();
    for (int i = 0; i < fb.size(); i++) begin
      if (gaps && i > 0) begin
        @(negedge clk);
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = fb[i];
      in_sop   = (i == 0) || (i == extra_sop);
      in_eop   = (i == fb.size() - 1);
      in_error = (i == err_at);
      is.push_back(cyc + 1);
    end
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic load_123();
    fb.delete();
    for (int i = 0; i < 9; i++) fb.push_back(8'h31 + 8'(i));
    fb.push_back(8'h26); fb.push_back(8'h39); fb.push_back(8'hF4); fb.push_back(8'hCB);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (o0_valid !== 1'b0 || o0_sop !== 1'b0 || o0_eop !== 1'b0 || o0_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got v=%b sop=%b eop=%b err=%b want all 0", o0_valid, o0_sop, o0_eop, o0_err);
    end
    checks++;
    if (o0_data !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %h want 00", o0_data);
    end
    checks++;
    if (s0_ok !== 32'd0 || s0_bad !== 32'd0 || s0_runts !== 16'd0) begin
      errors++; $display("FAIL reset_stats: got ok=%0d bad=%0d runts=%0d want 0", s0_ok, s0_bad, s0_runts);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame_123(input bit gaps, input bit corrupt, input bit phy_err, input string nm);
    logic exp_err;
    load_123();
    if (corrupt) fb[12] = 8'hCA;
    err_at = phy_err ? 2 : -1;
    exp_err = corrupt | phy_err;
    q0.delete(); q1.delete();
    drive_frame(gaps, -1);
    err_at = -1;
    checks++;
    if (q0.size() != 9) begin
      errors++; $display("FAIL %s_count: got %0d bytes want 9", nm, q0.size());
    end
    for (int j = 0; j < q0.size() && j < 9; j++) begin
      checks++;
      if (q0[j].d !== 8'h31 + 8'(j) || q0[j].sop !== (j == 0) || q0[j].eop !== (j == 8) ||
          q0[j].err !== ((j == 8) && exp_err) || q0[j].cyc != is[j+4]) begin
        errors++;
        $display("FAIL %s_byte%0d: got d=%h sop=%b eop=%b err=%b cyc=%0d want d=%h sop=%b eop=%b err=%b cyc=%0d",
                 nm, j, q0[j].d, q0[j].sop, q0[j].eop, q0[j].err, q0[j].cyc,
                 8'h31 + 8'(j), (j == 0), (j == 8), ((j == 8) && exp_err), is[j+4]);
      end
    end
    checks++;
    if (q1.size() != 9) begin
      errors++; $display("FAIL %s_min_count: got %0d want 9", nm, q1.size());
    end else if (q1[8].eop !== 1'b1 || q1[8].err !== 1'b1) begin
      errors++; $display("FAIL %s_min_short: got eop=%b err=%b want eop=1 err=1", nm, q1[8].eop, q1[8].err);
    end
  endtask

  task automatic test_runt();
    fb.delete();
    fb.push_back(8'hAA); fb.push_back(8'hBB); fb.push_back(8'hCC);
    q0.delete(); q1.delete();
    drive_frame(1'b0, -1);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL runt_output: got %0d/%0d bytes want 0/0", q0.size(), q1.size());
    end
    checks++;
    if (s0_runts !== (STATS ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL runt_stat: got %0d want %0d", s0_runts, STATS ? 1 : 0);
    end
  endtask

  task automatic test_min_len();
    fb.delete();
    for (int i = 0; i < 56; i++) fb.push_back(8'(i * 7 + 3));
    append_fcs();
    q0.delete(); q1.delete();
    drive_frame(1'b0, -1);
    checks++;
    if (q1.size() != 56) begin
      errors++; $display("FAIL minlen_count: got %0d want 56", q1.size());
    end
    for (int j = 0; j < q1.size() && j < 56; j++) begin
      checks++;
      if (q1[j].d !== 8'(j * 7 + 3) || q1[j].sop !== (j == 0) || q1[j].eop !== (j == 55) ||
          q1[j].err !== (j == 55) || q1[j].cyc != is[j+4]) begin
        errors++;
        $display("FAIL minlen_byte%0d: got d=%h sop=%b eop=%b err=%b cyc=%0d want d=%h sop=%b eop=%b err=%b cyc=%0d",
                 j, q1[j].d, q1[j].sop, q1[j].eop, q1[j].err, q1[j].cyc,
                 8'(j * 7 + 3), (j == 0), (j == 55), (j == 55), is[j+4]);
      end
    end
    checks++;
    if (q0.size() != 56) begin
      errors++; $display("FAIL minlen_nocheck_count: got %0d want 56", q0.size());
    end else if (q0[55].eop !== 1'b1 || q0[55].err !== 1'b0) begin
      errors++; $display("FAIL minlen_nocheck_eop: got eop=%b err=%b want eop=1 err=0", q0[55].eop, q0[55].err);
    end
  endtask

  task automatic test_abort();
    logic [7:0] ed;
    logic       es, ee, er;
    int         ec;
    load_123();
    for (int i = 18; i >= 0; i--) fb.push_front(8'h80 + 8'(i));
    q0.delete(); q1.delete();
    drive_frame(1'b0, 19);
    checks++;
    if (q0.size() != 25) begin
      errors++; $display("FAIL abort_count: got %0d want 25", q0.size());
    end
    for (int m = 0; m < q0.size() && m < 25; m++) begin
      if (m < 16) begin
        ed = 8'h80 + 8'(m); es = (m == 0); ee = (m == 15); er = (m == 15); ec = is[m+4];
      end else begin
        ed = 8'h31 + 8'(m - 16); es = (m == 16); ee = (m == 24); er = 1'b0; ec = is[m+7];
      end
      checks++;
      if (q0[m].d !== ed || q0[m].sop !== es || q0[m].eop !== ee || q0[m].err !== er || q0[m].cyc != ec) begin
        errors++;
        $display("FAIL abort_byte%0d: got d=%h sop=%b eop=%b err=%b cyc=%0d want d=%h sop=%b eop=%b err=%b cyc=%0d",
                 m, q0[m].d, q0[m].sop, q0[m].eop, q0[m].err, q0[m].cyc, ed, es, ee, er, ec);
      end
    end
  endtask

  task automatic test_stats();
    checks++;
    if (s0_ok !== (STATS ? 32'd4 : 32'd0)) begin
      errors++; $display("FAIL stats_ok: got %0d want %0d", s0_ok, STATS ? 4 : 0);
    end
    checks++;
    if (s0_bad !== (STATS ? 32'd3 : 32'd0)) begin
      errors++; $display("FAIL stats_bad: got %0d want %0d", s0_bad, STATS ? 3 : 0);
    end
    checks++;
    if (s0_runts !== (STATS ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL stats_runts: got %0d want %0d", s0_runts, STATS ? 1 : 0);
    end
  endtask

  task automatic test_reset_midframe();
    int neop;
    q0.delete(); q1.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h50 + 8'(i); in_sop = (i == 0); in_eop = 1'b0; in_error = 1'b0;
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0; in_sop = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (o0_valid !== 1'b0 || o0_eop !== 1'b0 || o0_data !== 8'h00) begin
      errors++; $display("FAIL midrst_outputs: got v=%b eop=%b d=%h want 0/0/00", o0_valid, o0_eop, o0_data);
    end
    checks++;
    if (s0_ok !== 32'd0 || s0_bad !== 32'd0 || s0_runts !== 16'd0) begin
      errors++; $display("FAIL midrst_stats: got ok=%0d bad=%0d runts=%0d want 0", s0_ok, s0_bad, s0_runts);
    end
    @(negedge clk);
    rst = 1'b0;
    // Bytes without a sop must be ignored after reset returns the FSM to idle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hE0 + 8'(i); in_sop = 1'b0; in_eop = (i == 5);
    end
    @(negedge clk);
    in_valid = 1'b0; in_eop = 1'b0;
    repeat (4) @(negedge clk);
    neop = 0;
    foreach (q0[k]) if (q0[k].eop) neop++;
    checks++;
    if (q0.size() != 5 || neop != 0) begin
      errors++; $display("FAIL midrst_stream: got %0d bytes %0d eops want 5 bytes 0 eops", q0.size(), neop);
    end
  endtask

  initial begin
    test_reset();
    test_frame_123(1'b0, 1'b0, 1'b0, "good");
    test_frame_123(1'b0, 1'b1, 1'b0, "badfcs");
    test_frame_123(1'b1, 1'b0, 1'b0, "gaps");
    test_frame_123(1'b0, 1'b0, 1'b1, "phyerr");
    test_runt();
    test_min_len();
    test_abort();
    test_stats();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
